// File: rtl/csa_stream_xor.sv
// CSA stream-layer descrambling front end: issues keystream requests per block,
// aligns returning keystream through a delay line, and buffers results in an output FIFO.
module csa_stream_xor #(
    parameter int KS_LAT     = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [3:0]  in_bytes,
    input  logic        in_bypass,
    output logic        ks_valid,
    output logic        ks_init,
    output logic [63:0] ks_sb,
    input  logic [63:0] ks_cb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [3:0]  out_bytes,
    output logic        err_abort,
    output logic [15:0] drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 70;

    typedef enum logic [0:0] {
        WAIT_SOP = 1'b0,
        IN_PKT   = 1'b1
    } state_t;

    state_t        state_r, state_nxt;
    logic [CW-1:0] credit_r;
    logic          bypass_r;
    logic          err_abort_r;
    logic [15:0]   drop_cnt_r;
    logic          accept_s, issue_s, drop_s, start_s, abort_s;
    logic          pkt_bypass_s;
    logic [3:0]    eff_bytes_s;

    logic [63:0]   dl_data   [KS_LAT];
    logic          dl_valid  [KS_LAT];
    logic          dl_sop    [KS_LAT];
    logic          dl_eop    [KS_LAT];
    logic          dl_first  [KS_LAT];
    logic          dl_bypass [KS_LAT];
    logic [3:0]    dl_bytes  [KS_LAT];

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_r, rd_ptr_r;
    logic          push_s, pop_s, empty_s;
    logic [63:0]   exit_word_s;
    logic [EW-1:0] rd_entry_s;

    // Zero every byte lane at or above the valid byte count.
    function automatic logic [63:0] mask_bytes(input logic [63:0] w, input logic [3:0] n);
        logic [63:0] r;
        r = w;
        for (int i = 0; i < 8; i++) begin
            if (i >= int'(n)) begin
                r[8*i +: 8] = 8'h00;
            end else begin
                r[8*i +: 8] = w[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Credit covers both in-flight and buffered blocks, so the FIFO can never overflow.
    assign in_ready = (credit_r < CW'(FIFO_DEPTH)) && !rst;
    assign accept_s = in_valid && in_ready;

    // Packet FSM next-state and per-block decode.
    always_comb begin
        state_nxt = state_r;
        issue_s   = 1'b0;
        drop_s    = 1'b0;
        start_s   = 1'b0;
        abort_s   = 1'b0;
        if (accept_s) begin
            case (state_r)
                WAIT_SOP: begin
                    if (in_sop) begin
                        issue_s   = 1'b1;
                        start_s   = 1'b1;
                        state_nxt = in_eop ? WAIT_SOP : IN_PKT;
                    end else begin
                        drop_s    = 1'b1;
                    end
                end
                IN_PKT: begin
                    issue_s = 1'b1;
                    if (in_sop) begin
                        start_s   = 1'b1;
                        abort_s   = 1'b1;
                        state_nxt = in_eop ? WAIT_SOP : IN_PKT;
                    end else if (in_eop) begin
                        state_nxt = WAIT_SOP;
                    end else begin
                        state_nxt = IN_PKT;
                    end
                end
                default: state_nxt = WAIT_SOP;
            endcase
        end else begin
            state_nxt = state_r;
        end
    end

    // Keystream request and effective byte count for the accepted block.
    always_comb begin
        pkt_bypass_s = start_s ? in_bypass : bypass_r;
        ks_valid     = issue_s;
        ks_init      = issue_s && start_s && !in_bypass;
        ks_sb        = ks_init ? in_data : 64'd0;
        if (in_eop && (in_bytes != 4'd0) && (in_bytes <= 4'd8)) begin
            eff_bytes_s = in_bytes;
        end else begin
            eff_bytes_s = 4'd8;
        end
    end

    // FSM state, packet bypass flag, abort pulse and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= WAIT_SOP;
            bypass_r    <= 1'b0;
            err_abort_r <= 1'b0;
            drop_cnt_r  <= 16'd0;
        end else begin
            state_r     <= state_nxt;
            err_abort_r <= abort_s;
            if (start_s) begin
                bypass_r <= in_bypass;
            end
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    // Delay line that lines each block up with its keystream word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KS_LAT; i++) begin
                dl_valid[i]  <= 1'b0;
                dl_data[i]   <= 64'd0;
                dl_sop[i]    <= 1'b0;
                dl_eop[i]    <= 1'b0;
                dl_first[i]  <= 1'b0;
                dl_bypass[i] <= 1'b0;
                dl_bytes[i]  <= 4'd0;
            end
        end else begin
            dl_valid[0]  <= issue_s;
            dl_data[0]   <= in_data;
            dl_sop[0]    <= in_sop;
            dl_eop[0]    <= in_eop;
            dl_first[0]  <= start_s;
            dl_bypass[0] <= pkt_bypass_s;
            dl_bytes[0]  <= eff_bytes_s;
            for (int i = 1; i < KS_LAT; i++) begin
                dl_valid[i]  <= dl_valid[i-1];
                dl_data[i]   <= dl_data[i-1];
                dl_sop[i]    <= dl_sop[i-1];
                dl_eop[i]    <= dl_eop[i-1];
                dl_first[i]  <= dl_first[i-1];
                dl_bypass[i] <= dl_bypass[i-1];
                dl_bytes[i]  <= dl_bytes[i-1];
            end
        end
    end

    // Init blocks and bypass packets pass through; everything else is XORed with keystream.
    always_comb begin
        if (dl_first[KS_LAT-1] || dl_bypass[KS_LAT-1]) begin
            exit_word_s = mask_bytes(dl_data[KS_LAT-1], dl_bytes[KS_LAT-1]);
        end else begin
            exit_word_s = mask_bytes(dl_data[KS_LAT-1] ^ ks_cb, dl_bytes[KS_LAT-1]);
        end
    end

    assign push_s     = dl_valid[KS_LAT-1];
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign pop_s      = out_valid && out_ready;
    assign rd_entry_s = fifo_mem[rd_ptr_r[AW-1:0]];

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_r[AW-1:0]] <= {exit_word_s, dl_sop[KS_LAT-1],
                                           dl_eop[KS_LAT-1], dl_bytes[KS_LAT-1]};
        end
    end

    // FIFO pointers and credit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            credit_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
            case ({issue_s, pop_s})
                2'b10:   credit_r <= credit_r + CW'(1);
                2'b01:   credit_r <= credit_r - CW'(1);
                default: credit_r <= credit_r;
            endcase
        end
    end

    // Outputs are forced low during reset.
    always_comb begin
        out_valid = !empty_s && !rst;
        if (out_valid) begin
            out_data  = rd_entry_s[69:6];
            out_sop   = rd_entry_s[5];
            out_eop   = rd_entry_s[4];
            out_bytes = rd_entry_s[3:0];
        end else begin
            out_data  = 64'd0;
            out_sop   = 1'b0;
            out_eop   = 1'b0;
            out_bytes = 4'd0;
        end
        err_abort = err_abort_r && !rst;
        drop_cnt  = rst ? 16'd0 : drop_cnt_r;
    end

endmodule

// File: tb/tb_csa_stream_xor.sv
// Self-checking bench for csa_stream_xor: vector table plus hand-written sequences,
// with a keystream model and an output scoreboard.
module tb_csa_stream_xor;

    localparam int KS_LAT     = 16;
    localparam int FIFO_DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sop, in_eop, in_bypass;
    logic [63:0] in_data;
    logic [3:0]  in_bytes;
    logic        ks_valid, ks_init;
    logic [63:0] ks_sb, ks_cb;
    logic        out_valid, out_ready, out_sop, out_eop;
    logic [63:0] out_data;
    logic [3:0]  out_bytes;
    logic        err_abort;
    logic [15:0] drop_cnt;

    csa_stream_xor #(.KS_LAT(KS_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_bytes(in_bytes), .in_bypass(in_bypass),
        .ks_valid(ks_valid), .ks_init(ks_init), .ks_sb(ks_sb), .ks_cb(ks_cb),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_bytes(out_bytes),
        .err_abort(err_abort), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int init_cnt = 0;
    int abort_cnt = 0;
    logic [63:0] ks_word = 64'd0;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [3:0]  bytes;
        logic        lat;
        int          t;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [3:0]  bytes;
        logic [63:0] ks;
        logic        init;
        logic [63:0] exp_data;
        logic [3:0]  exp_bytes;
    } vec_t;
    vec_t vecs[8];

    // Keystream generator model: garbage on init/idle slots exposes misalignment.
    logic [63:0] ks_pipe [KS_LAT];
    always @(posedge clk) begin
        ks_pipe[0] <= ks_valid ? (ks_init ? 64'hA5A5_5A5A_DEAD_BEEF : ks_word)
                               : 64'hC0FF_EE00_C0FF_EE00;
        for (int i = 1; i < KS_LAT; i++) ks_pipe[i] <= ks_pipe[i-1];
    end
    assign ks_cb = ks_pipe[KS_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] d, input logic [63:0] ks,
                                          input logic pass, input logic [3:0] n);
        logic [63:0] w;
        w = pass ? d : (d ^ ks);
        for (int i = 0; i < 8; i++) if (i >= int'(n)) w[8*i +: 8] = 8'h00;
        return w;
    endfunction

    // Output monitor / scoreboard.
    always begin
        @(negedge clk); #2;
        if (ks_valid) chk("ks_valid_without_ready", {63'd0, in_ready}, 64'd1);
        if (ks_valid && ks_init) init_cnt++;
        if (err_abort) abort_cnt++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", out_data, 64'd0);
                if (out_data === 64'd0) begin
                    errors++;
                    $display("FAIL unexpected_output: actual=valid required=none");
                end
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_sop", {63'd0, out_sop}, {63'd0, e.sop});
                chk("out_eop", {63'd0, out_eop}, {63'd0, e.eop});
                chk("out_bytes", {60'd0, out_bytes}, {60'd0, e.bytes});
                if (e.lat) chk("latency", 64'(cyc - e.t), 64'(KS_LAT + 1));
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic s, input logic e, input logic [3:0] b,
                        input logic byp, input logic drop, input logic init, input logic [63:0] ks,
                        input logic [63:0] exp_d, input logic [3:0] exp_b, input logic lat,
                        output int waited);
        exp_t x;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_bytes = b; in_bypass = byp;
        ks_word = ks;
        #1;
        waited = 0;
        while (!in_ready && waited < 300) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        chk("ks_valid", {63'd0, ks_valid}, {63'd0, !drop});
        if (!drop) begin
            chk("ks_init", {63'd0, ks_init}, {63'd0, init});
            chk("ks_sb", ks_sb, init ? d : 64'd0);
            x.data = exp_d; x.sop = s; x.eop = e; x.bytes = exp_b; x.lat = lat; x.t = cyc;
            sb.push_back(x);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Send one block with expectation from the bench model.
    task automatic blk(input logic [63:0] d, input logic s, input logic e, input logic [3:0] b,
                       input logic byp, input logic drop, input logic first, input logic [63:0] ks);
        int w;
        logic [3:0] n;
        n = (e && b != 4'd0 && b <= 4'd8) ? b : 4'd8;
        send(d, s, e, b, byp, drop, first && !byp, ks, model(d, ks, first || byp, n), n, 1'b0, w);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int w;
        vecs[0] = '{64'h0011223344556677, 1, 0, 4'd8, 64'hFFFFFFFFFFFFFFFF, 1, 64'h0011223344556677, 4'd8};
        vecs[1] = '{64'h1111111111111111, 0, 0, 4'd3, 64'hFFFFFFFFFFFFFFFF, 0, 64'hEEEEEEEEEEEEEEEE, 4'd8};
        vecs[2] = '{64'h2222222222222222, 0, 1, 4'd8, 64'hFFFFFFFFFFFFFFFF, 0, 64'hDDDDDDDDDDDDDDDD, 4'd8};
        vecs[3] = '{64'h0123456789ABCDEF, 1, 0, 4'd8, 64'h0F0F0F0F0F0F0F0F, 1, 64'h0123456789ABCDEF, 4'd8};
        vecs[4] = '{64'hAAAAAAAAAAAAAAAA, 0, 1, 4'd3, 64'h0F0F0F0F0F0F0F0F, 0, 64'h0000000000A5A5A5, 4'd3};
        vecs[5] = '{64'h8877665544332211, 1, 1, 4'd5, 64'hFFFFFFFFFFFFFFFF, 1, 64'h0000005544332211, 4'd5};
        vecs[6] = '{64'h5555555555555555, 1, 0, 4'd8, 64'hFF00FF00FF00FF00, 1, 64'h5555555555555555, 4'd8};
        vecs[7] = '{64'h3C3C3C3C3C3C3C3C, 0, 1, 4'd0, 64'hFF00FF00FF00FF00, 0, 64'hC33CC33CC33CC33C, 4'd8};

        rst = 1'b1; in_valid = 1'b0; in_data = 64'd0; in_sop = 1'b0; in_eop = 1'b0;
        in_bytes = 4'd0; in_bypass = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_ks_valid", {63'd0, ks_valid}, 64'd0);
        chk("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

        // Table-driven: 3-block packet, partial eop, single-block, eop with in_bytes=0.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data, vecs[i].sop, vecs[i].eop, vecs[i].bytes, 1'b0, 1'b0, vecs[i].init,
                 vecs[i].ks, vecs[i].exp_data, vecs[i].exp_bytes, 1'b1, w);
            chk("table_no_stall", 64'(w), 64'd0);
            if (i == 2) chk("pkt1_init_count", 64'(init_cnt), 64'd1);
        end
        drain();

        // Backpressure: exactly FIFO_DEPTH blocks accepted while out_ready is low.
        out_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            send(64'h1000_0000_0000_0000 + 64'(i), i == 0, 1'b0, 4'd8, 1'b0, 1'b0, i == 0,
                 64'h00FF_00FF_00FF_00FF,
                 model(64'h1000_0000_0000_0000 + 64'(i), 64'h00FF_00FF_00FF_00FF, i == 0, 4'd8),
                 4'd8, 1'b0, w);
            chk("bp_no_stall", 64'(w), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = 64'h7777_7777_7777_7777; in_sop = 1'b0; in_eop = 1'b1;
        in_bytes = 4'd8;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (k % 10 == 0) chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        blk(64'h7777_7777_7777_7777, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 64'h00FF_00FF_00FF_00FF);
        drain();

        // Five orphan blocks are dropped, then a clean packet.
        for (int i = 0; i < 5; i++)
            blk(64'hBAD0_0000_0000_0000 + 64'(i), 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0, 64'd0);
        #1;
        chk("drop_cnt_5", {48'd0, drop_cnt}, 64'd5);
        blk(64'h0102030405060708, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0);
        blk(64'h1112131415161718, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0);
        drain();

        // sop mid-packet after two blocks.
        blk(64'hA1A1A1A1A1A1A1A1, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 64'h0F0F_F0F0_0F0F_F0F0);
        blk(64'hA2A2A2A2A2A2A2A2, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 64'h0F0F_F0F0_0F0F_F0F0);
        blk(64'hB1B1B1B1B1B1B1B1, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 64'h0F0F_F0F0_0F0F_F0F0);
        blk(64'hB2B2B2B2B2B2B2B2, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 64'h0F0F_F0F0_0F0F_F0F0);
        repeat (2) @(negedge clk);
        chk("abort_pulses", 64'(abort_cnt), 64'd1);
        drain();

        // Bypass packet passes unmodified with no init request.
        init_cnt = 0;
        blk(64'hFEDCBA9876543210, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 64'hFFFF_0000_FFFF_0000);
        blk(64'h0F1E2D3C4B5A6978, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 64'hFFFF_0000_FFFF_0000);
        drain();
        chk("bypass_no_init", 64'(init_cnt), 64'd0);

        // Reset mid-stream discards in-flight blocks.
        blk(64'hC1C1C1C1C1C1C1C1, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 64'h3333_3333_3333_3333);
        blk(64'hC2C2C2C2C2C2C2C2, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 64'h3333_3333_3333_3333);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        #1;
        chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mid_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (KS_LAT + 4) @(negedge clk);
        #1;
        chk("no_partial_output", {63'd0, out_valid}, 64'd0);
        chk("post_rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        blk(64'hD1D2D3D4D5D6D7D8, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 64'h5555_AAAA_5555_AAAA);
        blk(64'hE1E2E3E4E5E6E7E8, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 64'h5555_AAAA_5555_AAAA);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
